// File: rtl/cs_final_adder_pipe.sv
// Purpose : pipelined carry-propagate adder that resolves a carry-save pair into the final product.
// Latency : STAGES cycles from input transfer to out_valid; one result per cycle sustained.
// Backpr. : single global enable (advance = !out_valid || out_ready); a stalled output freezes every stage.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      input handshake for the carry-save pair cs_a/cs_b
//   out_valid/out_ready    output handshake for sum/carry_out
//   sum, carry_out         (cs_a + cs_b) mod 2^WIDTH and bit WIDTH of the true sum
//   ovf_clr, ovf_sticky    present only when CS_ADDER_OVF_FLAG_EN is defined:
//                          sticky flag set by any output transfer with carry_out=1,
//                          cleared by ovf_clr (set wins on a same-cycle conflict)
//
// WIDTH must be divisible by STAGES. Stage k adds segment k of the operands plus the
// carry from stage k-1, appends it to the already-resolved lower segments and forwards
// only the still-unprocessed upper operand segments.

module cs_final_adder_pipe #(
    parameter int WIDTH  = 128,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] cs_a,
    input  logic [WIDTH-1:0] cs_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef CS_ADDER_OVF_FLAG_EN
    ,
    input  logic             ovf_clr,
    output logic             ovf_sticky
`endif
);

    localparam int SEG = WIDTH / STAGES;

    // Global pipeline enable: depends only on registered state and out_ready,
    // never on in_valid.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // Operand bits still unprocessed when entering this stage.
            localparam int IN_W = WIDTH - k * SEG;
            // Result bits resolved once this stage has run.
            localparam int LO_W = (k + 1) * SEG;

            logic [IN_W-1:0] a_in;
            logic [IN_W-1:0] b_in;
            logic            v_in;
            logic            c_in;
            logic [SEG:0]    seg_sum;
            logic [LO_W-1:0] s_next;

            logic            v_q;
            logic            c_q;
            logic [LO_W-1:0] s_q;

            if (k == 0) begin : g_first
                assign a_in   = cs_a;
                assign b_in   = cs_b;
                assign v_in   = in_valid;
                assign c_in   = 1'b0;
                assign s_next = seg_sum[SEG-1:0];
            end else begin : g_next
                assign a_in   = g_stage[k-1].g_rem.a_q;
                assign b_in   = g_stage[k-1].g_rem.b_q;
                assign v_in   = g_stage[k-1].v_q;
                assign c_in   = g_stage[k-1].c_q;
                assign s_next = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
            end

            assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                           + {{SEG{1'b0}}, c_in};

            // Data is cleared on reset so the output reads zero immediately;
            // afterwards it simply follows the pipeline, bubbles included.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (advance) begin
                    v_q <= v_in;
                    c_q <= seg_sum[SEG];
                    s_q <= s_next;
                end
            end

            // Upper operand segments travel with the partial result; the last
            // stage has nothing left to forward.
            if (k < STAGES - 1) begin : g_rem
                logic [IN_W-SEG-1:0] a_q;
                logic [IN_W-SEG-1:0] b_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (advance) begin
                        a_q <= a_in[IN_W-1:SEG];
                        b_q <= b_in[IN_W-1:SEG];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign carry_out = g_stage[STAGES-1].c_q;

`ifdef CS_ADDER_OVF_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && carry_out) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cs_final_adder_pipe.sv
// Bench for cs_final_adder_pipe: directed vector table, handshake corner sequences,
// randomized traffic against a queue-based reference of cs_a+cs_b, and a carry-save
// multiplier front end modelled with plain 3:2 compression.
module tb_cs_final_adder_pipe;

    localparam int W  = 128;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] cs_a;
    logic [W-1:0] cs_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef CS_ADDER_OVF_FLAG_EN
    logic         ovf_clr;
    logic         ovf_sticky;
`endif

    cs_final_adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cs_a      (cs_a),
        .cs_b      (cs_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef CS_ADDER_OVF_FLAG_EN
        ,
        .ovf_clr   (ovf_clr),
        .ovf_sticky(ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int out_cnt = 0;

    logic [W:0]   exp_q[$];
    logic         hold_pend = 1'b0;
    logic [W+1:0] held;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: scoreboard and hold-stability work at the negedge, then step
    // to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (hold_pend)
            check("hold_stable", {out_valid, carry_out, sum}, held);
        hold_pend = out_valid && !out_ready && !rst;
        held      = {out_valid, carry_out, sum};
        if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got output %h required none", sum);
            end else begin
                check("sb_result", {1'b0, carry_out, sum}, {1'b0, exp_q.pop_front()});
            end
        end
        if (in_valid && in_ready)
            exp_q.push_back({1'b0, cs_a} + {1'b0, cs_b});
        @(posedge clk);
        #1;
    endtask

    // Single isolated transfer with out_ready high: checks latency and result.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W:0] exp, input string name);
        int lat;
        out_ready = 1'b1;
        cs_a      = a;
        cs_b      = b;
        in_valid  = 1'b1;
        #1;
        check({name, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 4 * ST) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, ST);
        check({name, "_sum"}, {1'b0, carry_out, sum}, {1'b0, exp});
        tick();
`ifdef CS_ADDER_OVF_FLAG_EN
        check({name, "_ovf"}, ovf_sticky, exp[W]);
        if (exp[W]) begin
            ovf_clr = 1'b1;
            tick();
            ovf_clr = 1'b0;
            check({name, "_ovf_clr"}, ovf_sticky, 0);
        end
`endif
    endtask

    // Shift-and-add multiplier kept in carry-save form with 3:2 compressors.
    task automatic csa_mul(input logic [63:0] a, input logic [63:0] b,
                           output logic [W-1:0] s, output logic [W-1:0] c);
        logic [W-1:0] pp;
        logic [W-1:0] t;
        s = '0;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            pp = a[i] ? ({64'b0, b} << i) : '0;
            t  = s ^ c ^ pp;
            c  = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
        end
    endtask

    initial begin
        logic [W-1:0] ms, mc;
        logic [63:0]  ma[5];
        logic [63:0]  mb[5];
        logic         pend;
        logic         fire;
        int           sent, sent_at_10, base, stalls, n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        cs_a      = '0;
        cs_b      = '0;
        out_ready = 1'b1;
`ifdef CS_ADDER_OVF_FLAG_EN
        ovf_clr   = 1'b0;
`endif

        vt[0] = '{a: 128'd45, b: 128'd0, exp: 129'd45};
        vt[1] = '{a: {1'b0, {127{1'b1}}}, b: 128'd1, exp: {2'b01, 127'b0}};
        vt[2] = '{a: {128{1'b1}}, b: 128'd1, exp: {1'b1, 128'b0}};
        vt[3] = '{a: {128{1'b1}}, b: {128{1'b1}}, exp: {1'b1, {127{1'b1}}, 1'b0}};
        vt[4] = '{a: {32'b0, {96{1'b1}}}, b: 128'd1, exp: {33'b1, 96'b0}};
        vt[5] = '{a: 128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
                  b: 128'h00000000_FFFFFFFF_00000001_00000000,
                  exp: {1'b1, 128'b0}};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry_out, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef CS_ADDER_OVF_FLAG_EN
        check("rst_ovf", ovf_sticky, 0);
`endif
        rst = 1'b0;
        tick();

        // Directed vectors.
        for (int i = 0; i < 6; i++)
            run_one(vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i));

        // Backpressure: 8 back-to-back pairs, out_ready low in cycles 3..10.
        sent = 0;
        sent_at_10 = 0;
        base = out_cnt;
        cs_a = rnd128();
        cs_b = rnd128();
        for (int i = 0; i < 60 && (sent < 8 || exp_q.size() != 0); i++) begin
            out_ready = !(i >= 3 && i <= 10);
            in_valid  = (sent < 8);
            #1;
            if (i == 6) check("bp_in_ready_low", in_ready, 0);
            if (i == 10) sent_at_10 = sent;
            fire = in_valid && in_ready;
            tick();
            if (fire) begin
                sent++;
                cs_a = rnd128();
                cs_b = rnd128();
            end
        end
        in_valid = 1'b0;
        check("bp_held_pairs", sent_at_10, 4);
        check("bp_out_count", out_cnt - base, 8);
        check("bp_drained", exp_q.size(), 0);

        // Full throughput: no stalls, one result per cycle once filled.
        out_ready = 1'b1;
        stalls = 0;
        base = out_cnt;
        for (int i = 0; i < 20; i++) begin
            cs_a = rnd128();
            cs_b = (i % 2) ? ~cs_a : rnd128();
            in_valid = 1'b1;
            #1;
            if (!in_ready) stalls++;
            tick();
        end
        in_valid = 1'b0;
        check("tput_stalls", stalls, 0);
        check("tput_steady", out_cnt - base, 20 - ST);
        repeat (ST) tick();
        check("tput_total", out_cnt - base, 20);

        // Random traffic with random backpressure.
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                cs_a = rnd128();
                cs_b = ($urandom_range(0, 1) != 0) ? rnd128() : (~cs_a + 128'($urandom_range(0, 2)));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            fire = in_valid && in_ready;
            tick();
            pend = in_valid && !fire;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("rand_drained", exp_q.size(), 0);
`ifdef CS_ADDER_OVF_FLAG_EN
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("rand_ovf_clr", ovf_sticky, 0);
`endif

        // Multiplier chain through a carry-save front end.
        ma[0] = 64'd15;  mb[0] = 64'd3;
        ma[1] = '1;      mb[1] = '1;
        ma[2] = 64'd4;   mb[2] = 64'd5;
        ma[3] = {$urandom, $urandom}; mb[3] = {$urandom, $urandom};
        ma[4] = {$urandom, $urandom}; mb[4] = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            csa_mul(ma[i], mb[i], ms, mc);
            run_one(ms, mc, {1'b0, {64'b0, ma[i]} * {64'b0, mb[i]}}, $sformatf("mul%0d", i));
        end

        // Mid-flight reset with three pairs in flight and the head stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cs_a = rnd128();
            cs_b = rnd128();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        hold_pend = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_carry", carry_out, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_stale", out_valid, 0);
        end
        run_one(128'd1000, 128'd24, 129'd1024, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
